sts_detector: RTL and testbench

- Receive-side counterpart of the STS generator: detects the 802.11a short training sequence in a baseband sample stream.
- Uses delay-and-correlate (lag 16) against a windowed energy.
- Sits after the ADC/decimation front end and ahead of the LTS/symbol-timing blocks.
- Asserts a sticky detect flag and reports the sample index at which the STS plateau is confirmed.

---
 rtl/sts_detector.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sts_detector.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sts_detector.sv
// sts_detector: 802.11a short-training-sequence detector.
// Lag-16 delay-and-correlate against a 16-sample windowed energy, followed by
// a plateau counter that declares detection after PLAT_LEN consecutive
// qualifying samples. Pipeline: stage 0 (products), stage 1 (running sums),
// stage 2 (threshold compare), stage 3 (FSM); each stage advances only on a
// valid token, so detection latency is independent of rx_dv gaps.
// Optional feature: define STS_DET_CFO_OUT_EN to add cfo_re/cfo_im outputs
// that capture the correlator sums of the token that completed the plateau.
module sts_detector #(
  parameter int THR_NUM    = 6,
  parameter int MIN_ENERGY = 1024,
  parameter int PLAT_LEN   = 48,
  parameter int IDX_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_clr,
  input  logic                    rx_dv,
  input  logic signed [7:0]       rx_re,
  input  logic signed [7:0]       rx_im,
  output logic                    sts_det,
  output logic [IDX_W-1:0]        det_index,
  output logic [1:0]              det_state
`ifdef STS_DET_CFO_OUT_EN
  ,
  output logic signed [20:0]      cfo_re,
  output logic signed [20:0]      cfo_im
`endif
);

  localparam logic [1:0] ST_FILL     = 2'd0;
  localparam logic [1:0] ST_SEARCH   = 2'd1;
  localparam logic [1:0] ST_DETECTED = 2'd2;
  localparam int         CNT_W       = $clog2(PLAT_LEN + 1);

  logic [1:0] state;
  logic       accept;

  // Stage 0 state
  logic signed [7:0]  dre [16];
  logic signed [7:0]  dim [16];
  logic [IDX_W-1:0]   smp_cnt;
  logic               v0, mv0;
  logic [IDX_W-1:0]   idx0;
  logic signed [16:0] p0_re, p0_im;
  logic [15:0]        e0;

  // Stage 1 state
  logic signed [16:0] pd_re [16];
  logic signed [16:0] pd_im [16];
  logic [15:0]        ed [16];
  logic signed [20:0] c_re, c_im;
  logic [19:0]        p_sum;
  logic               v1, mv1;
  logic [IDX_W-1:0]   idx1;

  // Stage 2 state
  logic               v2, mv2, ok2;
  logic [IDX_W-1:0]   idx2;
`ifdef STS_DET_CFO_OUT_EN
  logic signed [20:0] c2_re, c2_im;
`endif

  // Stage 3 state
  logic [CNT_W-1:0]   plat_cnt;
  logic [CNT_W-1:0]   cnt_inc;

  // Once detected, the front end stops consuming samples.
  assign accept = rx_dv && (state != ST_DETECTED);

  // Stage 0 arithmetic: lag-16 product and instantaneous energy, 17-bit signed.
  logic signed [16:0] re_x, im_x, dre_x, dim_x, p_re_c, p_im_c, e_c;
  assign re_x   = 17'(rx_re);
  assign im_x   = 17'(rx_im);
  assign dre_x  = 17'(dre[15]);
  assign dim_x  = 17'(dim[15]);
  assign p_re_c = re_x * dre_x + im_x * dim_x;
  assign p_im_c = im_x * dre_x - re_x * dim_x;
  assign e_c    = re_x * re_x + im_x * im_x;

  // Stage 0: sample delay line, product/energy registers, sample index.
  // NOTE: all sequential state uses non-blocking assignments so every stage
  // reads the previous-cycle value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay lines are reset explicitly because stale taps would
      // corrupt the first window after a clear; they cannot be left as plain RAM.
      for (int i = 0; i < 16; i++) begin
        dre[i] <= '0;
        dim[i] <= '0;
      end
      smp_cnt <= '0;
      v0      <= 1'b0;
      mv0     <= 1'b0;
      idx0    <= '0;
      p0_re   <= '0;
      p0_im   <= '0;
      e0      <= '0;
    end else if (rx_clr) begin
      for (int i = 0; i < 16; i++) begin
        dre[i] <= '0;
        dim[i] <= '0;
      end
      smp_cnt <= '0;
      v0      <= 1'b0;
      mv0     <= 1'b0;
      idx0    <= '0;
      p0_re   <= '0;
      p0_im   <= '0;
      e0      <= '0;
    end else begin
      v0 <= accept;
      if (accept) begin
        dre[0] <= rx_re;
        dim[0] <= rx_im;
        for (int i = 1; i < 16; i++) begin
          dre[i] <= dre[i-1];
          dim[i] <= dim[i-1];
        end
        p0_re <= p_re_c;
        p0_im <= p_im_c;
        e0    <= 16'(e_c);
        idx0  <= smp_cnt;
        mv0   <= (smp_cnt >= IDX_W'(31));
        if (smp_cnt != '1) smp_cnt <= smp_cnt + IDX_W'(1);
      end
    end
  end

  // Stage 1: 16-sample running sums of product (C) and energy (P).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        pd_re[i] <= '0;
        pd_im[i] <= '0;
        ed[i]    <= '0;
      end
      c_re  <= '0;
      c_im  <= '0;
      p_sum <= '0;
      v1    <= 1'b0;
      mv1   <= 1'b0;
      idx1  <= '0;
    end else if (rx_clr) begin
      for (int i = 0; i < 16; i++) begin
        pd_re[i] <= '0;
        pd_im[i] <= '0;
        ed[i]    <= '0;
      end
      c_re  <= '0;
      c_im  <= '0;
      p_sum <= '0;
      v1    <= 1'b0;
      mv1   <= 1'b0;
      idx1  <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        c_re  <= c_re + 21'(p0_re) - 21'(pd_re[15]);
        c_im  <= c_im + 21'(p0_im) - 21'(pd_im[15]);
        p_sum <= p_sum + 20'(e0) - 20'(ed[15]);
        pd_re[0] <= p0_re;
        pd_im[0] <= p0_im;
        ed[0]    <= e0;
        for (int i = 1; i < 16; i++) begin
          pd_re[i] <= pd_re[i-1];
          pd_im[i] <= pd_im[i-1];
          ed[i]    <= ed[i-1];
        end
        mv1  <= mv0;
        idx1 <= idx0;
      end
    end
  end

  // Stage 2 arithmetic: 8*(|C_re|+|C_im|) against THR_NUM*P at 26 bits.
  logic [20:0] abs_re, abs_im;
  logic [22:0] mag;
  logic [25:0] lhs, rhs;
  assign abs_re = c_re[20] ? 21'(-c_re) : 21'(c_re);
  assign abs_im = c_im[20] ? 21'(-c_im) : 21'(c_im);
  assign mag    = 23'(abs_re) + 23'(abs_im);
  assign lhs    = {mag, 3'b000};
  assign rhs    = 26'(THR_NUM) * 26'(p_sum);

  // Stage 2: register the per-token qualification decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      mv2  <= 1'b0;
      ok2  <= 1'b0;
      idx2 <= '0;
`ifdef STS_DET_CFO_OUT_EN
      c2_re <= '0;
      c2_im <= '0;
`endif
    end else if (rx_clr) begin
      v2   <= 1'b0;
      mv2  <= 1'b0;
      ok2  <= 1'b0;
      idx2 <= '0;
`ifdef STS_DET_CFO_OUT_EN
      c2_re <= '0;
      c2_im <= '0;
`endif
    end else begin
      v2 <= v1;
      if (v1) begin
        ok2  <= (lhs >= rhs) && (p_sum >= 20'(MIN_ENERGY));
        mv2  <= mv1;
        idx2 <= idx1;
`ifdef STS_DET_CFO_OUT_EN
        c2_re <= c_re;
        c2_im <= c_im;
`endif
      end
    end
  end

  assign cnt_inc = plat_cnt + CNT_W'(1);

  // Stage 3: FILL/SEARCH/DETECTED state machine with plateau counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      plat_cnt  <= '0;
      sts_det   <= 1'b0;
      det_index <= '0;
`ifdef STS_DET_CFO_OUT_EN
      cfo_re <= '0;
      cfo_im <= '0;
`endif
    end else if (rx_clr) begin
      state     <= ST_FILL;
      plat_cnt  <= '0;
      sts_det   <= 1'b0;
      det_index <= '0;
`ifdef STS_DET_CFO_OUT_EN
      cfo_re <= '0;
      cfo_im <= '0;
`endif
    end else if (v2 && mv2 && (state != ST_DETECTED)) begin
      if (ok2 && (cnt_inc == CNT_W'(PLAT_LEN))) begin
        state     <= ST_DETECTED;
        plat_cnt  <= cnt_inc;
        sts_det   <= 1'b1;
        det_index <= idx2;
`ifdef STS_DET_CFO_OUT_EN
        cfo_re <= c2_re;
        cfo_im <= c2_im;
`endif
      end else begin
        state    <= ST_SEARCH;
        plat_cnt <= ok2 ? cnt_inc : '0;
      end
    end
  end

  assign det_state = state;

endmodule

// File: tb/tb_sts_detector.sv
// Directed testbench for sts_detector: clean STS (back-to-back and gapped),
// zero and non-periodic streams, mid-plateau rx_clr and rst_n, and sample
// index saturation. Inputs change 1 time unit after the rising edge; outputs
// are sampled at the same point.
module tb_sts_detector;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_clr;
  logic               rx_dv;
  logic signed [7:0]  rx_re;
  logic signed [7:0]  rx_im;
  logic               sts_det;
  logic [15:0]        det_index;
  logic [1:0]         det_state;
`ifdef STS_DET_CFO_OUT_EN
  logic signed [20:0] cfo_re;
  logic signed [20:0] cfo_im;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_acc  = 0;
  int acc78     = 0;
  int rise_cyc  = 0;
  bit seen      = 1'b0;

  logic signed [7:0] pat_re [16];
  logic signed [7:0] pat_im [16];

  sts_detector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_clr    (rx_clr),
    .rx_dv     (rx_dv),
    .rx_re     (rx_re),
    .rx_im     (rx_im),
    .sts_det   (sts_det),
    .det_index (det_index),
    .det_state (det_state)
`ifdef STS_DET_CFO_OUT_EN
    ,
    .cfo_re    (cfo_re),
    .cfo_im    (cfo_im)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record the edge on which sts_det first appears after arming.
  always @(posedge clk) begin
    #1;
    if (sts_det && !seen) begin
      seen     = 1'b1;
      rise_cyc = cyc;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [7:0] sts_re(input int i);
    return (i == 0) ? 8'sd6 : pat_re[i % 16];
  endfunction

  function automatic logic signed [7:0] sts_im(input int i);
    return (i == 0) ? 8'sd6 : pat_im[i % 16];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [7:0] re, input logic signed [7:0] im, input int gap);
    rx_re = re;
    rx_im = im;
    rx_dv = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    rx_dv = 1'b0;
    idle(gap);
  endtask

  task automatic send_sts(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      send(sts_re(i), sts_im(i), gap);
      if (i == 78) acc78 = last_acc;
    end
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    idle(1);
    rx_clr = 1'b0;
  endtask

  task automatic check_detect78(input string tag);
    int lat;
    lat = seen ? (rise_cyc - acc78) : -1;
    total_cnt++;
    if (sts_det !== 1'b1) $display("FAIL %s sts_det: got %b want 1", tag, sts_det);
    else pass_cnt++;
    total_cnt++;
    if (det_index !== 16'd78) $display("FAIL %s det_index: got %0d want 78", tag, det_index);
    else pass_cnt++;
    total_cnt++;
    if (det_state !== 2'd2) $display("FAIL %s det_state: got %0d want 2", tag, det_state);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL %s latency: got %0d edges want 3", tag, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rx_clr = 1'b0;
    rx_dv  = 1'b0;
    rx_re  = '0;
    rx_im  = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    total_cnt++;
    if (sts_det !== 1'b0) $display("FAIL reset sts_det: got %b want 0", sts_det);
    else pass_cnt++;
    total_cnt++;
    if (det_index !== 16'd0) $display("FAIL reset det_index: got %0d want 0", det_index);
    else pass_cnt++;
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL reset det_state: got %0d want 0", det_state);
    else pass_cnt++;
  endtask

  task automatic test_clean(input int gap, input string tag);
`ifdef STS_DET_CFO_OUT_EN
    int exp_re;
    int exp_im;
`endif
    pulse_clr();
    seen = 1'b0;
    send_sts(0, 159, gap);
    idle(4);
    check_detect78(tag);
`ifdef STS_DET_CFO_OUT_EN
    exp_re = 0;
    exp_im = 0;
    for (int k = 63; k <= 78; k++) begin
      exp_re += sts_re(k) * sts_re(k - 16) + sts_im(k) * sts_im(k - 16);
      exp_im += sts_im(k) * sts_re(k - 16) - sts_re(k) * sts_im(k - 16);
    end
    total_cnt++;
    if (int'(cfo_re) !== exp_re) $display("FAIL %s cfo_re: got %0d want %0d", tag, cfo_re, exp_re);
    else pass_cnt++;
    total_cnt++;
    if (int'(cfo_im) !== exp_im) $display("FAIL %s cfo_im: got %0d want %0d", tag, cfo_im, exp_im);
    else pass_cnt++;
`endif
  endtask

  task automatic test_zero();
    pulse_clr();
    for (int i = 0; i <= 30; i++) send(8'sd0, 8'sd0, 0);
    idle(3);
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL zero fill state: got %0d want 0", det_state);
    else pass_cnt++;
    send(8'sd0, 8'sd0, 0);
    idle(2);
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL zero token31 early: got %0d want 0", det_state);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (det_state !== 2'd1) $display("FAIL zero token31 search: got %0d want 1", det_state);
    else pass_cnt++;
    for (int i = 32; i < 200; i++) send(8'sd0, 8'sd0, 0);
    idle(4);
    total_cnt++;
    if (sts_det !== 1'b0) $display("FAIL zero sts_det: got %b want 0", sts_det);
    else pass_cnt++;
    total_cnt++;
    if (det_state !== 2'd1) $display("FAIL zero final state: got %0d want 1", det_state);
    else pass_cnt++;
  endtask

  task automatic test_ramp();
    logic signed [7:0] a;
    pulse_clr();
    for (int n = 0; n < 200; n++) begin
      a = 8'((n % 37) - 18);
      send(a, a, 0);
    end
    idle(4);
    total_cnt++;
    if (sts_det !== 1'b0) $display("FAIL ramp sts_det: got %b want 0", sts_det);
    else pass_cnt++;
    total_cnt++;
    if (det_state !== 2'd1) $display("FAIL ramp state: got %0d want 1", det_state);
    else pass_cnt++;
    total_cnt++;
    if (det_index !== 16'd0) $display("FAIL ramp det_index: got %0d want 0", det_index);
    else pass_cnt++;
  endtask

  task automatic test_clr_mid();
    pulse_clr();
    send_sts(0, 59, 0);
    total_cnt++;
    if (det_state !== 2'd1) $display("FAIL clrmid pre state: got %0d want 1", det_state);
    else pass_cnt++;
    rx_re  = sts_re(60);
    rx_im  = sts_im(60);
    rx_dv  = 1'b1;
    rx_clr = 1'b1;
    idle(1);
    rx_dv  = 1'b0;
    rx_clr = 1'b0;
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL clrmid state: got %0d want 0", det_state);
    else pass_cnt++;
    idle(3);
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL clrmid flushed state: got %0d want 0", det_state);
    else pass_cnt++;
    total_cnt++;
    if (sts_det !== 1'b0) $display("FAIL clrmid sts_det: got %b want 0", sts_det);
    else pass_cnt++;
    seen = 1'b0;
    send_sts(0, 159, 0);
    idle(4);
    check_detect78("clrmid");
  endtask

  task automatic test_rst_mid();
    pulse_clr();
    send_sts(0, 69, 0);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (det_state !== 2'd0) $display("FAIL rstmid state: got %0d want 0", det_state);
    else pass_cnt++;
    total_cnt++;
    if (sts_det !== 1'b0) $display("FAIL rstmid sts_det: got %b want 0", sts_det);
    else pass_cnt++;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    seen = 1'b0;
    send_sts(0, 159, 0);
    idle(4);
    check_detect78("rstmid");
  endtask

  task automatic test_saturation();
    pulse_clr();
    for (int i = 0; i < 65540; i++) send(8'sd0, 8'sd0, 0);
    send_sts(0, 159, 0);
    idle(4);
    total_cnt++;
    if (sts_det !== 1'b1) $display("FAIL sat sts_det: got %b want 1", sts_det);
    else pass_cnt++;
    total_cnt++;
    if (det_index !== 16'hFFFF) $display("FAIL sat det_index: got %0d want 65535", det_index);
    else pass_cnt++;
  endtask

  initial begin
    pat_re = '{8'sd12, -8'sd34, -8'sd3, 8'sd36, 8'sd24, 8'sd36, -8'sd3, -8'sd34,
               8'sd12, 8'sd1, -8'sd20, -8'sd3, 8'sd0, -8'sd3, -8'sd20, 8'sd1};
    pat_im = '{8'sd12, 8'sd1, -8'sd20, -8'sd3, 8'sd0, -8'sd3, -8'sd20, 8'sd1,
               8'sd12, -8'sd34, -8'sd3, 8'sd36, 8'sd24, 8'sd36, -8'sd3, -8'sd34};
    test_reset();
    test_clean(0, "clean");
    test_clean(2, "gapped");
    test_zero();
    test_ramp();
    test_clr_mid();
    test_rst_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
